multimode_ring_counter: RTL and testbench
=========================================

# multimode_ring_counter

Parametrised shift-register counter that generalises the one-hot ring counter. It runs as a ring (one-hot) or a Johnson (twisted-ring) counter, shifts in either direction, and supports count enable and parallel load. It raises a terminal-count pulse each time the sequence returns to its home state. It is the standard sequencer and phase generator for timing-strobe and state-decoding logic elsewhere in the sequential library.

## Interface
- `N`, default 4: counter width in flip-flops; legal range N ≥ 2.
- `clk`  in  1  rising-edge clock.
- `clear`  in  1  synchronous, active-high reset.
- `en`  in  1  count enable; one shift per cycle while high.
- `load`  in  1  synchronous parallel load of `load_val`.
- `load_val`  in  N  value loaded when `load` = 1.
- `mode`  in  1  0 = ring, 1 = Johnson; sampled every cycle.
- `dir`  in  1  0 = rotate right (toward bit 0), 1 = rotate left (toward bit N-1).
- `q`  out  N  counter state, registered.
- `tc`  out  1  terminal-count pulse, registered.
- `illegal`  out  1  current `q` is not a legal state for the current `mode`; combinational.

## Operation
- Home state: ring = one-hot MSB (bit N-1 = 1, others 0); Johnson = all zeros.
- Per-cycle priority: `clear` > `load` > `en` > hold.
- `clear`: `q` ← home state of the `mode` sampled in that cycle; `tc` ← 0.
- `load`: `q` ← `load_val` unchanged, with no legality check on the load; `tc` ← 0.
- Step, `dir` = 0: `q[k]` ← `q[k+1]` for k < N-1; `q[N-1]` ← `q[0]` in ring mode, `~q[0]` in Johnson mode.
- Step, `dir` = 1: `q[k]` ← `q[k-1]` for k > 0; `q[0]` ← `q[N-1]` in ring mode, `~q[N-1]` in Johnson mode.
- Hold (`en` = 0, no clear or load): `q` unchanged; `tc` ← 0.
- Sequence period: ring = N steps; Johnson = 2N steps.
- Legality:
  - Ring: popcount(`q`) = 1.
  - Johnson: the number of k in 0..N-2 with `q[k]` ≠ `q[k+1]` is ≤ 1.
  - `illegal` is evaluated against the current `mode`.
- `tc` is 1 for exactly one cycle, in the cycle after a step whose result equals the home state. It is 0 otherwise.
- Changing `mode` mid-count takes effect on the next edge, with no flush. A state that becomes illegal under the new mode is handled per Configuration.
- Changing `dir` mid-count reverses the sequence from the current state.

## Timing
- Reset: `q` = home state for the `mode` sampled during `clear`; `tc` = 0. `illegal` = 0 for as long as `mode` stays unchanged.
- Load, step and clear: 1-cycle latency; the result is visible on `q` after the active edge.
- `tc` asserts in the same cycle that `q` shows the home state reached by a step.
- `clear` asserted mid-sequence overrides everything in that cycle, including an asserted `load`.
- `illegal` follows `q` and `mode` combinationally within the cycle.

## Configuration
- `RING_SELF_CORRECT_EN` defined:
  - A step taken while `illegal` = 1 loads the home state for the current `mode`, not the shifted value.
  - If `tc` would apply, it asserts after that step.
  - Recovery from any state takes at most 1 step.
- `RING_SELF_CORRECT_EN` undefined:
  - Illegal states shift exactly like legal ones and are never repaired.
  - `illegal` is still reported.

## Test plan
- Ring rotate right, N=4: `clear` with `mode`=0, then `en`=1, `dir`=0 → `q` = 1000, 0100, 0010, 0001, 1000. `tc` = 1 only in the cycle `q` returns to 1000.
- Johnson rotate right, N=4: `clear` with `mode`=1, then `en`=1 → `q` = 0000, 1000, 1100, 1110, 1111, 0111, 0011, 0001, 0000. `tc` = 1 once, after the 8th step.
- Ring rotate left, N=4, from 1000 with `dir`=1 → `q` = 0001, 0010, 0100, 1000, with `tc` after the 4th step. Flipping `dir` at 0010 → next `q` = 0100.
- Priority: `clear`+`load` → home state. `load`=1, `load_val`=0010, `en`=1 → `q` = 0010 and `tc` = 0. `en`=0 for 3 cycles → `q` held and `tc` = 0.
- Illegal load, ring mode: `load_val` = 0110 → `illegal` = 1. With the macro, the next step gives 1000 with `illegal` = 0 and `tc` = 1. Without the macro, the next step gives 0011 with `illegal` still 1.
- Mode switch: ring at `q` = 0100, then `mode` → 1 → `illegal` = 1 (two transitions). With the macro, the next step gives 0000 and `tc` = 1. Without the macro, it gives 1010 (dir=0).

Source files
------------

// File: rtl/multimode_ring_counter.sv
// Purpose      : parametrised ring/Johnson shift-register counter with direction, enable, load, terminal count.
// Latency      : q and tc update one cycle after clear/load/en; illegal is combinational on q and mode.
// Backpressure : none; en is the only throttle, one shift per enabled cycle.
//
// Ports:
//   clk       rising-edge clock
//   clear     synchronous active-high reset; q <- home state of the mode sampled that cycle, tc <- 0
//   en        count enable, one shift per cycle
//   load      parallel load of load_val (no legality check); beats en, loses to clear
//   load_val  value loaded on load
//   mode      0 = ring (home 10..0), 1 = Johnson (home 00..0); sampled every cycle
//   dir       0 = shift toward bit 0, 1 = shift toward bit N-1
//   q         registered counter state
//   tc        registered one-cycle pulse when a step lands on the home state
//   illegal   combinational: q is not a legal state for the current mode
//
// Build option: RING_SELF_CORRECT_EN -- when defined, a step taken from an illegal
// state loads the home state instead of the shifted value. When undefined, illegal
// states shift like any other and are only reported.
module multimode_ring_counter #(
   parameter int N = 4
) (
   input  logic         clk,
   input  logic         clear,
   input  logic         en,
   input  logic         load,
   input  logic [N-1:0] load_val,
   input  logic         mode,
   input  logic         dir,
   output logic [N-1:0] q,
   output logic         tc,
   output logic         illegal
);

   logic [N-1:0] q_q, q_d;
   logic         tc_q, tc_d;

   logic [N-1:0] home;
   logic [N-1:0] shifted;
   logic [N-1:0] step_val;
   logic [N-2:0] edges;
   logic         fb;
   logic         ring_bad;
   logic         johnson_bad;

   always_comb begin
      home = mode ? '0 : {1'b1, {(N-1){1'b0}}};
   end

   // Ring legality is "exactly one bit set": nonzero and clearing the lowest set bit leaves zero.
   // Johnson legality is "at most one adjacent-bit transition": the edge vector is zero or one-hot.
   always_comb begin
      edges       = q_q[N-2:0] ^ q_q[N-1:1];
      ring_bad    = (q_q == '0) || ((q_q & (q_q - N'(1))) != '0);
      johnson_bad = (edges & (edges - (N-1)'(1))) != '0;
      illegal     = mode ? johnson_bad : ring_bad;
   end

   // Feedback bit is the bit falling off the end, inverted in Johnson mode.
   always_comb begin
      fb      = 1'b0;
      shifted = q_q;
      if (!dir) begin
         fb      = mode ? ~q_q[0] : q_q[0];
         shifted = {fb, q_q[N-1:1]};
      end else begin
         fb      = mode ? ~q_q[N-1] : q_q[N-1];
         shifted = {q_q[N-2:0], fb};
      end
   end

   always_comb begin
`ifdef RING_SELF_CORRECT_EN
      step_val = illegal ? home : shifted;
`else
      step_val = shifted;
`endif
   end

   // clear is handled in the flop block; load beats en, and only a step can raise tc.
   always_comb begin
      q_d  = q_q;
      tc_d = 1'b0;
      if (load) begin
         q_d = load_val;
      end else if (en) begin
         q_d  = step_val;
         tc_d = (step_val == home);
      end
   end

   always_ff @(posedge clk) begin
      if (clear) begin
         q_q  <= home;
         tc_q <= 1'b0;
      end else begin
         q_q  <= q_d;
         tc_q <= tc_d;
      end
   end

   assign q  = q_q;
   assign tc = tc_q;

endmodule

// File: tb/tb_multimode_ring_counter.sv
module tb_multimode_ring_counter;

   localparam int N = 4;
`ifdef RING_SELF_CORRECT_EN
   localparam bit SC = 1'b1;
`else
   localparam bit SC = 1'b0;
`endif

   logic         clk = 1'b0;
   logic         clear, en, load, mode, dir;
   logic [N-1:0] load_val;
   logic [N-1:0] q;
   logic         tc, illegal;

   int n_checks = 0;
   int n_fail   = 0;

   multimode_ring_counter #(.N(N)) dut (
      .clk      (clk),
      .clear    (clear),
      .en       (en),
      .load     (load),
      .load_val (load_val),
      .mode     (mode),
      .dir      (dir),
      .q        (q),
      .tc       (tc),
      .illegal  (illegal)
   );

   always #5 clk = ~clk;

   // ---------------- reference model (spec rules, plain arithmetic) ----------------
   logic [N-1:0] m_q;
   logic         m_tc;
   bit           m_valid = 1'b0;

   function automatic int popc(input logic [N-1:0] v);
      int c = 0;
      for (int i = 0; i < N; i++) c += int'(v[i]);
      return c;
   endfunction

   function automatic bit m_illegal(input logic [N-1:0] v, input logic md);
      int t = 0;
      for (int k = 0; k < N - 1; k++) if (v[k] != v[k+1]) t++;
      return md ? (t > 1) : (popc(v) != 1);
   endfunction

   function automatic logic [N-1:0] m_home(input logic md);
      logic [N-1:0] h = '0;
      if (!md) h[N-1] = 1'b1;
      return h;
   endfunction

   function automatic logic [N-1:0] m_step(input logic [N-1:0] v, input logic md, input logic dr);
      logic [N-1:0] r;
      if (!dr) begin
         r      = v >> 1;
         r[N-1] = md ? ~v[0] : v[0];
      end else begin
         r      = v << 1;
         r[0]   = md ? ~v[N-1] : v[N-1];
      end
      return r;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // One clock: model predicts from the inputs present at the edge, then DUT is compared.
   task automatic tick();
      logic [N-1:0] nq;
      logic         ntc;
      if (clear) begin
         nq = m_home(mode); ntc = 1'b0;
      end else if (load) begin
         nq = load_val; ntc = 1'b0;
      end else if (en) begin
         nq  = (SC && m_illegal(m_q, mode)) ? m_home(mode) : m_step(m_q, mode, dir);
         ntc = (nq == m_home(mode));
      end else begin
         nq = m_q; ntc = 1'b0;
      end
      if (clear) m_valid = 1'b1;
      @(posedge clk);
      #1;
      m_q  = nq;
      m_tc = ntc;
      if (m_valid) begin
         chk("model_q", 32'(q), 32'(m_q));
         chk("model_tc", 32'(tc), 32'(m_tc));
         chk("model_illegal", 32'(illegal), 32'(m_illegal(m_q, mode)));
      end
   endtask

   task automatic drive(input logic c, input logic l, input logic [N-1:0] lv,
                        input logic e, input logic md, input logic dr);
      clear = c; load = l; load_val = lv; en = e; mode = md; dir = dr;
   endtask

   // ---------------- directed vector table ----------------
   typedef struct {
      logic         clr, ld;
      logic [N-1:0] lv;
      logic         en, md, dr;
      logic [N-1:0] eq;
      logic         etc, eill;
   } vec_t;

   vec_t vecs[$];

   function automatic void add(input logic c, input logic l, input logic [N-1:0] lv,
                               input logic e, input logic md, input logic dr,
                               input logic [N-1:0] eq, input logic etc, input logic eill);
      vec_t v;
      v = '{c, l, lv, e, md, dr, eq, etc, eill};
      vecs.push_back(v);
   endfunction

   initial begin
      drive(0, 0, '0, 0, 0, 0);

      // Ring rotate right
      add(1,0,4'b0000,0,0,0, 4'b1000,0,0);
      add(0,0,4'b0000,1,0,0, 4'b0100,0,0);
      add(0,0,4'b0000,1,0,0, 4'b0010,0,0);
      add(0,0,4'b0000,1,0,0, 4'b0001,0,0);
      add(0,0,4'b0000,1,0,0, 4'b1000,1,0);
      // Johnson rotate right
      add(1,0,4'b0000,0,1,0, 4'b0000,0,0);
      add(0,0,4'b0000,1,1,0, 4'b1000,0,0);
      add(0,0,4'b0000,1,1,0, 4'b1100,0,0);
      add(0,0,4'b0000,1,1,0, 4'b1110,0,0);
      add(0,0,4'b0000,1,1,0, 4'b1111,0,0);
      add(0,0,4'b0000,1,1,0, 4'b0111,0,0);
      add(0,0,4'b0000,1,1,0, 4'b0011,0,0);
      add(0,0,4'b0000,1,1,0, 4'b0001,0,0);
      add(0,0,4'b0000,1,1,0, 4'b0000,1,0);
      // Ring rotate left
      add(1,0,4'b0000,0,0,1, 4'b1000,0,0);
      add(0,0,4'b0000,1,0,1, 4'b0001,0,0);
      add(0,0,4'b0000,1,0,1, 4'b0010,0,0);
      add(0,0,4'b0000,1,0,1, 4'b0100,0,0);
      add(0,0,4'b0000,1,0,1, 4'b1000,1,0);
      // Direction reversal mid-count: right to 0010, then left back to 0100
      add(0,0,4'b0000,1,0,0, 4'b0100,0,0);
      add(0,0,4'b0000,1,0,0, 4'b0010,0,0);
      add(0,0,4'b0000,1,0,1, 4'b0100,0,0);
      add(0,0,4'b0000,1,0,1, 4'b1000,1,0);
      // Priority: clear beats load, load beats en, hold keeps q with tc low
      add(1,1,4'b0010,1,0,0, 4'b1000,0,0);
      add(1,1,4'b0010,1,1,0, 4'b0000,0,0);
      add(0,1,4'b0010,1,0,0, 4'b0010,0,0);
      add(0,0,4'b0000,0,0,0, 4'b0010,0,0);
      add(0,0,4'b0000,0,0,0, 4'b0010,0,0);
      add(0,0,4'b0000,0,0,0, 4'b0010,0,0);
      // Loading the home state itself is not a step: no tc
      add(0,1,4'b1000,1,0,0, 4'b1000,0,0);
      add(0,0,4'b0000,1,0,0, 4'b0100,0,0);

      @(negedge clk);
      for (int i = 0; i < vecs.size(); i++) begin
         drive(vecs[i].clr, vecs[i].ld, vecs[i].lv, vecs[i].en, vecs[i].md, vecs[i].dr);
         tick();
         chk($sformatf("vec%0d_q", i), 32'(q), 32'(vecs[i].eq));
         chk($sformatf("vec%0d_tc", i), 32'(tc), 32'(vecs[i].etc));
         chk($sformatf("vec%0d_illegal", i), 32'(illegal), 32'(vecs[i].eill));
      end

      // ---------------- illegal load in ring mode ----------------
      drive(0, 1, 4'b0110, 0, 0, 0);
      tick();
      chk("illload_q", 32'(q), 32'(4'b0110));
      chk("illload_illegal", 32'(illegal), 32'd1);
      drive(0, 0, '0, 1, 0, 0);
      tick();
      if (SC) begin
         chk("illstep_q", 32'(q), 32'(4'b1000));
         chk("illstep_tc", 32'(tc), 32'd1);
         chk("illstep_illegal", 32'(illegal), 32'd0);
      end else begin
         chk("illstep_q", 32'(q), 32'(4'b0011));
         chk("illstep_tc", 32'(tc), 32'd0);
         chk("illstep_illegal", 32'(illegal), 32'd1);
      end

      // ---------------- mode switch ring -> Johnson at 0100 ----------------
      drive(1, 0, '0, 0, 0, 0);
      tick();
      drive(0, 0, '0, 1, 0, 0);
      tick();
      chk("msw_pre_q", 32'(q), 32'(4'b0100));
      chk("msw_pre_illegal", 32'(illegal), 32'd0);
      drive(0, 0, '0, 0, 1, 0);
      #1;
      chk("msw_comb_illegal", 32'(illegal), 32'd1);
      drive(0, 0, '0, 1, 1, 0);
      tick();
      if (SC) begin
         chk("msw_step_q", 32'(q), 32'(4'b0000));
         chk("msw_step_tc", 32'(tc), 32'd1);
      end else begin
         chk("msw_step_q", 32'(q), 32'(4'b1010));
         chk("msw_step_tc", 32'(tc), 32'd0);
         chk("msw_step_illegal", 32'(illegal), 32'd1);
      end

      // ---------------- randomized run against the model ----------------
      drive(1, 0, '0, 0, 0, 0);
      tick();
      for (int i = 0; i < 1500; i++) begin
         clear    = ($urandom_range(0, 49) == 0);
         load     = ($urandom_range(0, 9) == 0);
         load_val = N'($urandom);
         en       = ($urandom_range(0, 9) < 7);
         if ($urandom_range(0, 19) == 0) mode = ~mode;
         dir      = ($urandom_range(0, 3) == 0) ? ~dir : dir;
         tick();
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
